// File: rtl/bcd_stopwatch.sv
// Start/stop/clear stopwatch counting SS.hh as four BCD digits.
// Raw active-low keys are synchronised and debounced internally.
module bcd_stopwatch #(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       START_STOP_N,
    input  logic       CLEAR_N,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic [3:0] DIG2,
    output logic [3:0] DIG3,
    output logic       RUNNING,
    output logic       WRAP,
    output logic       OVF
);

    localparam int unsigned NKEY    = 2;
    localparam int unsigned KEY_SS  = 0;
    localparam int unsigned KEY_CLR = 1;
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TICK_W  = $clog2(TICK_DIV + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [NKEY-1:0]  raw;
    logic [NKEY-1:0]  sync1;
    logic [NKEY-1:0]  sync2;
    logic [NKEY-1:0]  lvl;
    logic [NKEY-1:0]  evt;
    logic [DEB_W-1:0] deb_cnt [NKEY];

    logic ss_evt;
    logic clr_evt;

    state_t state_q;
    state_t state_d;

    logic [TICK_W-1:0] presc;
    logic              tick;
    logic              wrap_c;
    logic [3:0]        dig0_d;
    logic [3:0]        dig1_d;
    logic [3:0]        dig2_d;
    logic [3:0]        dig3_d;

    assign raw     = {CLEAR_N, START_STOP_N};
    assign ss_evt  = evt[KEY_SS];
    assign clr_evt = evt[KEY_CLR];

    // Two-flop sync plus debounce; evt pulses once when a press (1 -> 0) is accepted.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1 <= '1;
            sync2 <= '1;
            lvl   <= '1;
            evt   <= '0;
            for (int k = 0; k < int'(NKEY); k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int k = 0; k < int'(NKEY); k++) begin
                evt[k] <= 1'b0;
                if (sync2[k] == lvl[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_W'(DEB_CYCLES - 1)) begin
                    lvl[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                    evt[k]     <= ~sync2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            RUNNING <= 1'b0;
        end else begin
            state_q <= state_d;
            RUNNING <= (state_d == RUN);
        end
    end

    // Clear overrides start/stop from every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_evt) state_d = RUN;
            RUN:     if (ss_evt) state_d = PAUSE;
            PAUSE:   if (ss_evt) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (clr_evt) begin
            state_d = IDLE;
        end
    end

    assign tick   = (state_q == RUN) && (presc == TICK_W'(TICK_DIV - 1));
    assign wrap_c = tick && (DIG0 == 4'd9) && (DIG1 == 4'd9)
                         && (DIG2 == 4'd9) && (DIG3 == 4'd5);

    // BCD ripple increment; the 59.99 rollover falls out as all digits returning to 0.
    always_comb begin
        dig0_d = DIG0;
        dig1_d = DIG1;
        dig2_d = DIG2;
        dig3_d = DIG3;
        if (tick) begin
            if (DIG0 == 4'd9) begin
                dig0_d = 4'd0;
                if (DIG1 == 4'd9) begin
                    dig1_d = 4'd0;
                    if (DIG2 == 4'd9) begin
                        dig2_d = 4'd0;
                        dig3_d = (DIG3 == 4'd5) ? 4'd0 : DIG3 + 4'd1;
                    end else begin
                        dig2_d = DIG2 + 4'd1;
                    end
                end else begin
                    dig1_d = DIG1 + 4'd1;
                end
            end else begin
                dig0_d = DIG0 + 4'd1;
            end
        end
    end

    // Prescaler only advances in RUN, so a pause keeps the partial tick.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            presc <= '0;
            DIG0  <= 4'd0;
            DIG1  <= 4'd0;
            DIG2  <= 4'd0;
            DIG3  <= 4'd0;
            WRAP  <= 1'b0;
            OVF   <= 1'b0;
        end else if (clr_evt) begin
            presc <= '0;
            DIG0  <= 4'd0;
            DIG1  <= 4'd0;
            DIG2  <= 4'd0;
            DIG3  <= 4'd0;
            WRAP  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                presc <= tick ? '0 : presc + TICK_W'(1);
            end
            DIG0 <= dig0_d;
            DIG1 <= dig1_d;
            DIG2 <= dig2_d;
            DIG3 <= dig3_d;
            WRAP <= wrap_c;
            OVF  <= OVF | wrap_c;
        end
    end

endmodule
